// File: rtl/dm_load_pkg.sv
// Shared encodings and helpers for the data-memory load path.
// DM_LOAD_MISALIGN_TRAP_EN (see dm_load_unit) uses is_misaligned.
package dm_load_pkg;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ld_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Per-request context held across the memory read.
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] low2;
  } ld_ctx_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] low2);
    case (op)
      LD_LW:         return low2 != 2'b00;
      LD_LH, LD_LHU: return low2[0];
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Byte/halfword select and sign/zero extension of a little-endian word.
// Purely combinational so a forwarding path can reuse it.
module dm_load_ext
  import dm_load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  op,
  input  logic [1:0]  low2,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{low2, 3'b000} +: 8];
    h = low2[1] ? word[31:16] : word[15:0];
    case (op)
      LD_LB:   data = {{24{b[7]}}, b};
      LD_LBU:  data = {24'b0, b};
      LD_LH:   data = {{16{h[15]}}, h};
      LD_LHU:  data = {16'b0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// Load unit: one word-aligned read per request, fixed read latency, extended result.
// DM_LOAD_MISALIGN_TRAP_EN: reject misaligned lh/lhu/lw instead of forcing alignment.
module dm_load_unit
  import dm_load_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_op,
  output logic              ld_ready,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              ld_misalign
);

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  ld_ctx_t           ctx_q, ctx_d;
  logic              mem_re_d, ld_valid_d, ld_misalign_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       ld_data_d, ext_data;
  logic              accept, reject;

  assign ld_ready = (state_q == S_IDLE || state_q == S_DONE) && !reset;
  assign accept   = ld_req && ld_ready;

`ifdef DM_LOAD_MISALIGN_TRAP_EN
  assign reject = !is_legal_op(ld_op) || is_misaligned(ld_op, ld_addr[1:0]);
`else
  assign reject = !is_legal_op(ld_op);
`endif

  dm_load_ext u_ext (
    .word (mem_rdata),
    .op   (ctx_q.op),
    .low2 (ctx_q.low2),
    .data (ext_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ctx_d         = ctx_q;
    mem_re_d      = 1'b0;
    mem_addr_d    = mem_addr;
    ld_valid_d    = 1'b0;
    ld_data_d     = 32'd0;
    ld_misalign_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (reject) begin
            // Rejected requests never touch memory; answer next cycle.
            state_d       = S_DONE;
            ld_valid_d    = 1'b1;
            ld_misalign_d = 1'b1;
          end else begin
            state_d    = S_WAIT;
            ctx_d.op   = ld_op;
            ctx_d.low2 = ld_addr[1:0];
            cnt_d      = LAT;
            mem_re_d   = 1'b1;
            mem_addr_d = {ld_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      S_WAIT: begin
        // Counter hits zero in the cycle mem_rdata is valid.
        if (cnt_q == 3'd0) begin
          state_d    = S_DONE;
          ld_valid_d = 1'b1;
          ld_data_d  = ext_data;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      ctx_q       <= '0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      ld_valid    <= 1'b0;
      ld_data     <= 32'd0;
      ld_misalign <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctx_q       <= ctx_d;
      mem_re      <= mem_re_d;
      mem_addr    <= mem_addr_d;
      ld_valid    <= ld_valid_d;
      ld_data     <= ld_data_d;
      ld_misalign <= ld_misalign_d;
    end
  end

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed bench for dm_load_unit at RD_LATENCY=1 and RD_LATENCY=3 (shared inputs).
module tb_dm_load_unit;

  localparam logic [31:0] WORD = 32'h81807F01;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_op;
  logic [31:0] mem_rdata;

  logic        ld_ready_1, mem_re_1, ld_valid_1, ld_misalign_1;
  logic [31:0] mem_addr_1, ld_data_1;
  logic        ld_ready_3, mem_re_3, ld_valid_3, ld_misalign_3;
  logic [31:0] mem_addr_3, ld_data_3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dm_load_unit #(.RD_LATENCY(1), .ADDR_W(32)) u_dut1 (
    .clk(clk), .reset(reset), .ld_req(ld_req), .ld_addr(ld_addr), .ld_op(ld_op),
    .ld_ready(ld_ready_1), .mem_re(mem_re_1), .mem_addr(mem_addr_1), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid_1), .ld_data(ld_data_1), .ld_misalign(ld_misalign_1)
  );

  dm_load_unit #(.RD_LATENCY(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .reset(reset), .ld_req(ld_req), .ld_addr(ld_addr), .ld_op(ld_op),
    .ld_ready(ld_ready_3), .mem_re(mem_re_3), .mem_addr(mem_addr_3), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid_3), .ld_data(ld_data_3), .ld_misalign(ld_misalign_3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Single load on the latency-1 instance; cycle 0 is the request cycle.
  task automatic run_l1(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] exp_data, input logic exp_mis,
                        input logic exp_re, input logic [31:0] exp_maddr);
    int cyc;
    ld_req = 1'b1; ld_op = op; ld_addr = addr;
    step();
    ld_req = 1'b0;
    chk({tag, "_mem_re"}, 32'(mem_re_1), 32'(exp_re));
    if (exp_re) chk({tag, "_mem_addr"}, mem_addr_1, exp_maddr);
    cyc = 1;
    while (!ld_valid_1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), exp_re ? 32'd3 : 32'd1);
    chk({tag, "_data"}, ld_data_1, exp_data);
    chk({tag, "_mis"}, 32'(ld_misalign_1), 32'(exp_mis));
    step();
    chk({tag, "_vld_drop"}, 32'(ld_valid_1), 32'd0);
    idle(6);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; ld_req = 1'b0; ld_addr = 32'd0; ld_op = 3'd0; mem_rdata = WORD;
    step();
    step();
    chk("rst_ready", 32'(ld_ready_1), 32'd0);
    chk("rst_mem_re", 32'(mem_re_1), 32'd0);
    chk("rst_mem_addr", mem_addr_1, 32'd0);
    chk("rst_valid", 32'(ld_valid_1), 32'd0);
    chk("rst_data", ld_data_1, 32'd0);
    chk("rst_mis", 32'(ld_misalign_1), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ld_ready_1), 32'd1);
    step();

    run_l1("lb_01",  3'd1, 32'h01, 32'h0000007F, 1'b0, 1'b1, 32'h00);
    run_l1("lb_03",  3'd1, 32'h03, 32'hFFFFFF81, 1'b0, 1'b1, 32'h00);
    run_l1("lbu_03", 3'd2, 32'h03, 32'h00000081, 1'b0, 1'b1, 32'h00);
    run_l1("lb_02",  3'd1, 32'h02, 32'hFFFFFF80, 1'b0, 1'b1, 32'h00);
    run_l1("lh_02",  3'd3, 32'h02, 32'hFFFF8180, 1'b0, 1'b1, 32'h00);
    run_l1("lhu_00", 3'd4, 32'h00, 32'h00007F01, 1'b0, 1'b1, 32'h00);
    run_l1("lhu_02", 3'd4, 32'h02, 32'h00008180, 1'b0, 1'b1, 32'h00);
    run_l1("lw_10",  3'd0, 32'h10, 32'h81807F01, 1'b0, 1'b1, 32'h10);
`ifdef DM_LOAD_MISALIGN_TRAP_EN
    run_l1("lw_12",  3'd0, 32'h12, 32'h00000000, 1'b1, 1'b0, 32'h00);
    run_l1("lh_01",  3'd3, 32'h01, 32'h00000000, 1'b1, 1'b0, 32'h00);
`else
    run_l1("lw_12",  3'd0, 32'h12, 32'h81807F01, 1'b0, 1'b1, 32'h10);
    run_l1("lh_01",  3'd3, 32'h01, 32'h00007F01, 1'b0, 1'b1, 32'h00);
`endif
    run_l1("op6",    3'd6, 32'h00, 32'h00000000, 1'b1, 1'b0, 32'h00);

    // Latency 3: data only sampled in cycle 4, request held during WAIT ignored.
    ld_req = 1'b1; ld_op = 3'd0; ld_addr = 32'h20; mem_rdata = 32'hDEADBEEF;
    chk("l3_ready_c0", 32'(ld_ready_3), 32'd1);
    step();
    chk("l3_mem_re_c1", 32'(mem_re_3), 32'd1);
    chk("l3_mem_addr_c1", mem_addr_3, 32'h20);
    step();
    chk("l3_mem_re_c2", 32'(mem_re_3), 32'd0);
    chk("l3_ready_c2", 32'(ld_ready_3), 32'd0);
    chk("l3_valid_c2", 32'(ld_valid_3), 32'd0);
    step();
    chk("l3_valid_c3", 32'(ld_valid_3), 32'd0);
    chk("l3_mem_addr_c3", mem_addr_3, 32'h20);
    step();
    ld_req = 1'b0; mem_rdata = 32'h12345678;
    chk("l3_valid_c4", 32'(ld_valid_3), 32'd0);
    step();
    mem_rdata = 32'hDEADBEEF;
    chk("l3_valid_c5", 32'(ld_valid_3), 32'd1);
    chk("l3_data_c5", ld_data_3, 32'h12345678);
    chk("l3_mis_c5", 32'(ld_misalign_3), 32'd0);
    step();
    chk("l3_valid_c6", 32'(ld_valid_3), 32'd0);
    chk("l3_data_c6", ld_data_3, 32'd0);
    chk("l3_no_queue_c6", 32'(mem_re_3), 32'd0);
    mem_rdata = WORD;
    idle(6);

    // Reset while a load is pending drops it.
    ld_req = 1'b1; ld_op = 3'd0; ld_addr = 32'h00;
    step();
    ld_req = 1'b0; reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(ld_ready_1), 32'd0);
    step();
    reset = 1'b0; mem_rdata = WORD;
    #1;
    chk("midrst_ready_after", 32'(ld_ready_1), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | ld_valid_1 | ld_valid_3;
      step();
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);

    // Back-to-back: second request presented in the DONE cycle.
    ld_req = 1'b1; ld_op = 3'd1; ld_addr = 32'h01;
    step();
    ld_req = 1'b0;
    step();
    step();
    chk("b2b_valid1", 32'(ld_valid_1), 32'd1);
    chk("b2b_data1", ld_data_1, 32'h0000007F);
    chk("b2b_ready_done", 32'(ld_ready_1), 32'd1);
    ld_req = 1'b1; ld_op = 3'd1; ld_addr = 32'h03;
    step();
    ld_req = 1'b0;
    chk("b2b_mem_re", 32'(mem_re_1), 32'd1);
    chk("b2b_valid_c4", 32'(ld_valid_1), 32'd0);
    step();
    chk("b2b_valid_c5", 32'(ld_valid_1), 32'd0);
    step();
    chk("b2b_valid2", 32'(ld_valid_1), 32'd1);
    chk("b2b_data2", ld_data_1, 32'hFFFFFF81);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
